// File: rtl/pipe_sched.sv
// Pipeline stall/flush scheduler with drain-and-halt FSM.
// Optional performance counters are built only when PIPE_SCHED_PERF_EN is defined.
module pipe_sched #(
  parameter int STAGES     = 6,
  parameter int ADDR_WIDTH = 32,
  parameter int JUMP_STAGE = 3,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [STAGES-1:0]     stallreq_i,
  input  logic                  jump_enable_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  halt_req_i,
  output logic [STAGES-1:0]     stall_o,
  output logic                  flush_jump_o,
  output logic [ADDR_WIDTH-1:0] new_pc_o,
  output logic                  halt_o,
  output logic [1:0]            state_o,
  output logic [CNT_WIDTH-1:0]  cyc_cnt_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int DW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(STAGES - 1);

  state_t                state, state_next;
  logic                  pending, pending_next;
  logic [ADDR_WIDTH-1:0] pend_addr, pend_addr_next;
  logic [DW-1:0]         drain_cnt, drain_cnt_next;
  logic [STAGES-1:0]     stall_mask;
  logic [STAGES-1:0]     stall;
  logic                  stalled_at_jump;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] new_pc;
  logic                  acc;

  // A stall at stage k holds every older stage 0..k.
  always_comb begin
    stall_mask = '0;
    acc        = 1'b0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      acc           = acc | stallreq_i[j];
      stall_mask[j] = acc;
    end
  end

  assign stalled_at_jump = stall_mask[JUMP_STAGE];

  // Redirect arbitration and FSM next state.
  always_comb begin
    state_next     = state;
    pending_next   = pending;
    pend_addr_next = pend_addr;
    drain_cnt_next = drain_cnt;
    flush          = 1'b0;
    new_pc         = '0;
    stall          = stall_mask;

    if (state != HALTED) begin
      if (pending) begin
        if (!stalled_at_jump) begin
          flush        = 1'b1;
          new_pc       = pend_addr;
          pending_next = 1'b0;
        end else begin
          pending_next = 1'b1;
        end
      end else if (jump_enable_i) begin
        if (!stalled_at_jump) begin
          flush  = 1'b1;
          new_pc = jump_addr_i;
        end else begin
          pending_next   = 1'b1;
          pend_addr_next = jump_addr_i;
        end
      end else begin
        pending_next = 1'b0;
      end
    end else begin
      pending_next = 1'b0;
    end

    case (state)
      RUN: begin
        if (halt_req_i) begin
          state_next     = DRAIN;
          drain_cnt_next = DRAIN_LOAD;
        end else begin
          state_next = RUN;
        end
      end
      DRAIN: begin
        stall[0] = 1'b1;
        // The counter reaches zero on the same edge that enters HALTED,
        // so DRAIN lasts STAGES-1 stall-free cycles.
        if (stallreq_i == '0) begin
          if (drain_cnt <= DW'(1)) begin
            state_next = HALTED;
          end else begin
            state_next = DRAIN;
          end
          drain_cnt_next = (drain_cnt == '0) ? '0 : drain_cnt - DW'(1);
        end else begin
          drain_cnt_next = drain_cnt;
        end
      end
      HALTED: begin
        stall      = '1;
        state_next = HALTED;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // State, pending redirect and drain counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RUN;
      pending   <= 1'b0;
      pend_addr <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      pending   <= pending_next;
      pend_addr <= pend_addr_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  assign stall_o      = rst_i ? '0 : stall;
  assign flush_jump_o = ~rst_i & flush;
  assign new_pc_o     = rst_i ? '0 : new_pc;
  assign halt_o       = ~rst_i & (state == HALTED);
  assign state_o      = rst_i ? 2'b00 : state;

`ifdef PIPE_SCHED_PERF_EN
  logic [CNT_WIDTH-1:0] cyc_cnt, stall_cnt, flush_cnt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    if (en && (v != '1)) begin
      return v + CNT_WIDTH'(1);
    end else begin
      return v;
    end
  endfunction

  // Saturating performance counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cyc_cnt   <= sat_inc(cyc_cnt, 1'b1);
      stall_cnt <= sat_inc(stall_cnt, stall[0]);
      flush_cnt <= sat_inc(flush_cnt, flush);
    end
  end

  assign cyc_cnt_o   = rst_i ? '0 : cyc_cnt;
  assign stall_cnt_o = rst_i ? '0 : stall_cnt;
  assign flush_cnt_o = rst_i ? '0 : flush_cnt;
`else
  assign cyc_cnt_o   = '0;
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
